// File: rtl/user_project_wb_initiator.sv
// Single-beat Wishbone classic initiator: takes one command over valid/ready, runs the bus
// cycle with a bounded ack timeout and returns read data plus an error flag over valid/ready.
module user_project_wb_initiator #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic [ERR_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = cmd_we_i;
                    sel_d       = cmd_sel_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    tmo_d       = '0;
                    state_d     = StBus;
                end
            end
            StBus: begin
                // Ack is checked first so an ack on the final timeout edge still succeeds.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (tmo_q == TmoLast) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d     = StResp;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_user_project_wb_initiator.sv
// Directed bench for user_project_wb_initiator: the bench plays sequencer, responder and
// response consumer; inputs change and outputs are sampled on the falling edge.
module tb_user_project_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    user_project_wb_initiator #(.TIMEOUT(16), .ERR_W(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (wdat),
        .wbm_dat_i  (rdat),
        .wbm_ack_i  (ack),
        .err_cnt_o  (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command and act as responder; ack_cycle is the 1-based stb cycle on which ack
    // is driven (0 = never). Returns the number of cycles stb was seen high.
    task automatic run_cmd(input logic c_we, input logic [31:0] c_adr, input logic [31:0] c_dat,
                           input logic [3:0] c_sel, input int ack_cycle,
                           input logic [31:0] r_dat, output int stb_cycles);
        bit done = 0;
        int k = 1;
        cmd_valid = 1'b1;
        cmd_we    = c_we;
        cmd_adr   = c_adr;
        cmd_dat   = c_dat;
        cmd_sel   = c_sel;
        check_eq("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cycle();
        cmd_valid = 1'b0;
        cmd_adr   = 32'hFFFF_FFFF;
        cmd_dat   = 32'hFFFF_FFFF;
        check_eq("cmd_ready_in_bus", {31'd0, cmd_ready}, 32'd0);
        while (!done && k <= 300) begin
            check_eq("stb", {31'd0, stb}, 32'd1);
            check_eq("cyc", {31'd0, cyc}, 32'd1);
            check_eq("we", {31'd0, we}, {31'd0, c_we});
            check_eq("adr", adr, c_adr);
            check_eq("wdat", wdat, c_dat);
            check_eq("sel", {28'd0, sel}, {28'd0, c_sel});
            check_eq("rsp_valid_in_bus", {31'd0, rsp_valid}, 32'd0);
            ack  = (k == ack_cycle);
            rdat = (k == ack_cycle) ? r_dat : 32'hDEAD_BEEF;
            cycle();
            ack  = 1'b0;
            rdat = 32'hDEAD_BEEF;
            if (!stb) done = 1;
            else k++;
        end
        check_eq("bus_bound", {31'd0, done}, 32'd1);
        stb_cycles = k;
        check_eq("cyc_after", {31'd0, cyc}, 32'd0);
        check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    endtask

    // Hold rsp_ready low for hold cycles (with stray ack and a pending command), then handshake.
    task automatic finish_rsp(input int hold, input logic [31:0] exp_dat, input logic exp_err);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            ack       = 1'b1;
            rdat      = 32'h1234_5678;
            check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("hold_dat", rsp_dat, exp_dat);
            check_eq("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check_eq("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check_eq("hold_stb", {31'd0, stb}, 32'd0);
            cycle();
        end
        ack       = 1'b0;
        rdat      = 32'hDEAD_BEEF;
        rsp_ready = 1'b1;
        check_eq("rsp_dat", rsp_dat, exp_dat);
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        cycle();
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check_eq("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        check_eq("no_accept_at_handshake", {31'd0, stb}, 32'd0);
        cmd_valid = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; rdat = 32'hDEAD_BEEF;
        @(negedge clk);
        cycle();
        check_eq("rst_cyc", {31'd0, cyc}, 32'd0);
        check_eq("rst_stb", {31'd0, stb}, 32'd0);
        check_eq("rst_adr", adr, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_dat", rsp_dat, 32'd0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;

        // Write through a 1-wait-state responder.
        run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'hCAFE_0000, n);
        check_eq("wr_stb_cycles", n, 32'd2);
        finish_rsp(0, 32'h0, 1'b0);

        // Read through a 1-wait-state responder, sel = 0 passed through.
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h0, 2, 32'h0000_0777, n);
        check_eq("rd_stb_cycles", n, 32'd2);
        finish_rsp(0, 32'h0000_0777, 1'b0);

        // Ack on the last allowed stb cycle wins over the timeout.
        run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3, 16, 32'hBEEF_0016, n);
        check_eq("late_ack_stb_cycles", n, 32'd16);
        check_eq("late_ack_err_cnt", {24'd0, err_cnt}, 32'd0);
        finish_rsp(0, 32'hBEEF_0016, 1'b0);

        // Back-pressure with stray acks and a pending command.
        run_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'h0BAD_F00D, n);
        check_eq("bp_stb_cycles", n, 32'd1);
        finish_rsp(5, 32'h0BAD_F00D, 1'b0);

        // Timeouts: first one, then saturation of the error counter.
        run_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 32'h0, n);
        check_eq("tmo_stb_cycles", n, 32'd16);
        check_eq("tmo_err_cnt", {24'd0, err_cnt}, 32'd1);
        finish_rsp(1, 32'h0, 1'b1);
        for (int i = 2; i <= 256; i++) begin
            run_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 32'h0, n);
            if (i == 255) check_eq("tmo_err_cnt_255", {24'd0, err_cnt}, 32'd255);
            finish_rsp(0, 32'h0, 1'b1);
        end
        check_eq("tmo_err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // Reset in the middle of a bus cycle.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_dat = 32'h1; cmd_sel = 4'hF;
        cycle();
        cmd_valid = 1'b0;
        check_eq("pre_rst_stb", {31'd0, stb}, 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        check_eq("mid_rst_stb", {31'd0, stb}, 32'd0);
        check_eq("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            cycle();
        end
        run_cmd(1'b1, 32'h3000_0060, 32'h5A5A_0F0F, 4'h6, 2, 32'h0, n);
        check_eq("post_rst_stb_cycles", n, 32'd2);
        finish_rsp(0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_project_wb_initiator.md
Name: user_project_wb_initiator

Overview:
Wishbone classic-cycle initiator (bus master) for exercising user-project Wishbone responders in the address-space test bench. It accepts one command at a time over a valid/ready interface and runs a single-beat Wishbone read or write. It waits for ack, with a bounded timeout, and returns read data plus an error flag over a valid/ready response interface. It sits between a test sequencer and a Wishbone slave port.

Parameters:
TIMEOUT, 16, bus cycles with cyc/stb held high before abort; legal range 1..255.
ERR_W, 8, width of the saturating error counter.

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  synchronous reset, active-high
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  initiator can accept a command
cmd_we_i  input  1  1=write, 0=read
cmd_adr_i  input  32  target address
cmd_dat_i  input  32  write data
cmd_sel_i  input  4  byte selects
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer accepts response
rsp_dat_o  output  32  read data; 0 for writes and errors
rsp_err_o  output  1  1=timeout abort
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge
err_cnt_o  output  ERR_W  count of timeouts, saturating

Behaviour:
- Clocking and reset:
  - Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
  - All outputs are registered.
- Reset values:
  - All wbm_* outputs = 0.
  - rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, err_cnt_o = 0.
  - State = IDLE, so cmd_ready_o = 1 from the first cycle after reset.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On the edge where cmd_valid_i && cmd_ready_o: latch we/adr/dat/sel onto the wbm_* outputs, set cyc = stb = 1, clear the timeout counter, go to BUS.
  - cmd_ready_o drops in the same edge.
- BUS:
  - cyc/stb/we/adr/sel/dat are held stable. cmd_ready_o = 0.
  - Each edge with wbm_ack_i = 1:
    - cyc = stb = 0, we = 0.
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write.
    - rsp_err_o = 0, rsp_valid_o = 1, go to RESP.
  - Each edge with no ack: the counter increments.
  - If the counter == TIMEOUT-1 and there is no ack:
    - cyc = stb = 0, rsp_dat_o = 0, rsp_err_o = 1, rsp_valid_o = 1.
    - err_cnt_o increments, saturating at all-ones.
    - Go to RESP.
  - cyc/stb are therefore high for exactly TIMEOUT cycles on abort.
  - Ack on the final timeout edge counts as success; ack wins.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held stable until rsp_ready_i = 1.
  - On the edge with rsp_ready_i: rsp_valid_o = 0, go to IDLE, cmd_ready_o = 1 next cycle.
  - No command is accepted in RESP.
- Ignored ack: wbm_ack_i in IDLE or RESP (a stale or late ack) is ignored and has no effect on any state or output.
- Latency:
  - Command accepted at edge E0; cyc/stb are high from E0.
  - With a responder that registers ack one edge after seeing stb: ack at E1, sampled at E2, rsp_valid_o high after E2.
  - Minimum command-to-command spacing with rsp_ready_i tied high: 4 cycles.
- Reset mid-transaction: at the reset edge cyc/stb drop to 0 and any pending response is discarded. Zero responses are emitted for the interrupted command. err_cnt_o returns to 0.
- Write data width: 32 bits. wbm_sel_o is passed through unmodified; sel = 0 is legal and passed as-is.

Test Plan:
1. Write adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF to a 1-wait-state responder -> wbm_adr/dat/sel are exact while stb is high; stb drops the edge after ack; rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
2. Read adr=0x3000_0010 from a responder returning 0x777 -> rsp_dat_o=0x0000_0777, rsp_err_o=0, wbm_we_o=0 throughout.
3. Read with ack never asserted, TIMEOUT=16 -> stb high exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=0, err_cnt_o=1; repeat 256 times with ERR_W=8 -> err_cnt_o saturates at 0xFF.
4. Ack asserted on the 16th stb cycle (TIMEOUT=16) -> rsp_err_o=0, read data captured, err_cnt_o unchanged.
5. Hold rsp_ready_i low 5 cycles after rsp_valid_o -> response is stable for all 5 cycles, cmd_ready_o=0, and a second cmd_valid_i is not accepted until the cycle after the handshake.
6. Assert wb_rst_i for 1 cycle while in BUS -> cyc/stb=0 next cycle, no rsp_valid_o pulse, cmd_ready_o=1 after reset, and a following write completes normally.
